// File: rtl/mac_seq_pkg.sv
// ============================================================================
// Module   : mac_seq_pkg
// Brief    : Shared state codes and datapath select constants for mac_seq_cu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD_A    = 3'd1,
      ST_LOAD_B    = 3'd2,
      ST_MULT      = 3'd3,
      ST_WRITE_RAM = 3'd4,
      ST_READ_RAM  = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   localparam logic DA_A  = 1'b0;
   localparam logic DA_B  = 1'b1;
   localparam logic SA_RF = 1'b0;
   localparam logic SB_RF = 1'b1;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mac_seq_wait_cnt.sv
// ============================================================================
// Module   : mac_seq_wait_cnt
// Brief    : Loadable down-counter with zero flag; times the multiplier wait.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_seq_wait_cnt #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mac_seq_cu.sv
// ============================================================================
// Module   : mac_seq_cu
// Brief    : Sequencer for a NUM_PAIRS multiply-accumulate job with RAM write.
//            Optional macro MAC_SEQ_READBACK_EN adds the READ_RAM state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_seq_cu
   import mac_seq_pkg::*;
#(
   parameter int RF_ADDR_W  = 3,
   parameter int RAM_ADDR_W = 3,
   parameter int NUM_PAIRS  = 2,
   parameter int MUL_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [RF_ADDR_W-1:0]  adr_a_base,
   input  logic [RF_ADDR_W-1:0]  adr_b_base,
   input  logic [RAM_ADDR_W-1:0] ram_adr_in,
   output logic [RF_ADDR_W-1:0]  rf_adr,
   output logic                  w_rf,
   output logic                  DA,
   output logic                  SA,
   output logic                  SB,
   output logic                  acc_clr,
   output logic                  acc_en,
   output logic                  w_ram,
   output logic [RAM_ADDR_W-1:0] ram_adr,
   output logic                  busy,
   output logic                  done,
   output logic [2:0]            st_out
);

   localparam int c_IDX_W = clog2_min1(NUM_PAIRS);
   localparam int c_CNT_W = clog2_min1(MUL_LAT);

   state_t                r_state;
   state_t                w_next;
   logic [c_IDX_W-1:0]    r_idx;
   logic [RF_ADDR_W-1:0]  r_a_base;
   logic [RF_ADDR_W-1:0]  r_b_base;
   logic [RAM_ADDR_W-1:0] r_ram_adr;
   logic                  w_cnt_zero;
   logic                  w_last_pair;

   assign w_last_pair = (r_idx == c_IDX_W'(NUM_PAIRS - 1));

   mac_seq_wait_cnt #(
      .WIDTH (c_CNT_W)
   ) u_wait_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (r_state == ST_LOAD_B),
      .i_load_val (c_CNT_W'(MUL_LAT - 1)),
      .i_dec      (r_state == ST_MULT),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Job parameters are captured once in IDLE so base inputs may move mid-job.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx     <= '0;
         r_a_base  <= '0;
         r_b_base  <= '0;
         r_ram_adr <= '0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_idx     <= '0;
         r_a_base  <= adr_a_base;
         r_b_base  <= adr_b_base;
         r_ram_adr <= ram_adr_in;
      end else if ((r_state == ST_MULT) && w_cnt_zero && !w_last_pair) begin
         r_idx     <= r_idx + c_IDX_W'(1);
      end
   end

   always_comb begin
      w_next  = r_state;
      rf_adr  = '0;
      w_rf    = 1'b0;
      DA      = 1'b0;
      SA      = 1'b0;
      SB      = 1'b0;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      w_ram   = 1'b0;
      ram_adr = '0;
      busy    = 1'b1;
      done    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) w_next = ST_LOAD_A;
         end
         ST_LOAD_A: begin
            w_rf    = 1'b1;
            rf_adr  = r_a_base + RF_ADDR_W'(r_idx);
            DA      = DA_A;
            SA      = SA_RF;
            SB      = SB_RF;
            acc_clr = (r_idx == '0);
            w_next  = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            w_rf   = 1'b1;
            rf_adr = r_b_base + RF_ADDR_W'(r_idx);
            DA     = DA_B;
            SA     = SA_RF;
            SB     = SB_RF;
            w_next = ST_MULT;
         end
         ST_MULT: begin
            if (w_cnt_zero) begin
               acc_en = 1'b1;
               w_next = w_last_pair ? ST_WRITE_RAM : ST_LOAD_A;
            end
         end
         ST_WRITE_RAM: begin
            w_ram   = 1'b1;
            ram_adr = r_ram_adr;
`ifdef MAC_SEQ_READBACK_EN
            w_next  = ST_READ_RAM;
`else
            w_next  = ST_DONE;
`endif
         end
`ifdef MAC_SEQ_READBACK_EN
         ST_READ_RAM: begin
            ram_adr = r_ram_adr;
            w_next  = ST_DONE;
         end
`endif
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: begin
            busy   = 1'b0;
            w_next = ST_IDLE;
         end
      endcase
   end

   assign st_out = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_cu.sv
// ============================================================================
// Module   : tb_mac_seq_cu
// Brief    : Directed self-checking bench for mac_seq_cu (MUL_LAT 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_seq_cu;

`ifdef MAC_SEQ_READBACK_EN
   localparam int c_RB = 1;
`else
   localparam int c_RB = 0;
`endif

   typedef struct {
      logic       start;
      logic [2:0] a, b, r;
      logic [2:0] st;
      logic [2:0] rf;
      logic [7:0] ctl;   // {w_rf,DA,SA,SB,acc_clr,acc_en,w_ram,busy}
      logic [2:0] ram;
      logic       done;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start1 = 1'b0;
   logic       start2 = 1'b0;
   logic [2:0] a_base = '0, b_base = '0, ram_in = '0;

   logic [2:0] rf1, ram1, st1, rf2, ram2, st2;
   logic w_rf1, da1, sa1, sb1, clr1, en1, wram1, busy1, done1;
   logic w_rf2, da2, sa2, sb2, clr2, en2, wram2, busy2, done2;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_five = 0;

   always #5 clk = ~clk;

   mac_seq_cu #(.RF_ADDR_W(3), .RAM_ADDR_W(3), .NUM_PAIRS(2), .MUL_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .adr_a_base(a_base), .adr_b_base(b_base),
      .ram_adr_in(ram_in), .rf_adr(rf1), .w_rf(w_rf1), .DA(da1), .SA(sa1), .SB(sb1),
      .acc_clr(clr1), .acc_en(en1), .w_ram(wram1), .ram_adr(ram1), .busy(busy1),
      .done(done1), .st_out(st1));

   mac_seq_cu #(.RF_ADDR_W(3), .RAM_ADDR_W(3), .NUM_PAIRS(2), .MUL_LAT(3)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .adr_a_base(a_base), .adr_b_base(b_base),
      .ram_adr_in(ram_in), .rf_adr(rf2), .w_rf(w_rf2), .DA(da2), .SA(sa2), .SB(sb2),
      .acc_clr(clr2), .acc_en(en2), .w_ram(wram2), .ram_adr(ram2), .busy(busy2),
      .done(done2), .st_out(st2));

   always @(negedge clk) begin
      if (st1 == 3'd5 || st2 == 3'd5) n_five++;
   end

   function automatic logic [19:0] obs1();
      return {st1, rf1, w_rf1, da1, sa1, sb1, clr1, en1, wram1, busy1, ram1, done1};
   endfunction

   function automatic logic [19:0] obs2();
      return {st2, rf2, w_rf2, da2, sa2, sb2, clr2, en2, wram2, busy2, ram2, done2};
   endfunction

   function automatic vec_t mk(input logic s, input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] r, input logic [2:0] st, input logic [2:0] rf,
                               input logic [7:0] ctl, input logic [2:0] ram, input logic d);
      vec_t v;
      v.start = s; v.a = a; v.b = b; v.r = r;
      v.st = st; v.rf = rf; v.ctl = ctl; v.ram = ram; v.done = d;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   vec_t vecs[$];
   int   exp_done;
   int   cyc;
   int   done_cyc;
   int   mult_cnt;
   logic [2:0] a_reads[$];
   int   acc_cyc[$];

   initial begin
      exp_done = 8 + c_RB;

      // Main job: a=3, b=5, ram=6; bases scrambled after the start cycle.
      vecs.push_back(mk(1'b1, 3'd3, 3'd5, 3'd6, 3'd1, 3'd3, 8'b1001_1001, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd5, 8'b1101_0001, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd0, 8'b0000_0101, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd4, 8'b1001_0001, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd6, 8'b1101_0001, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 3'd7, 3'd7, 3'd7, 3'd3, 3'd0, 8'b0000_0101, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 3'd7, 3'd7, 3'd7, 3'd4, 3'd0, 8'b0000_0011, 3'd6, 1'b0));
`ifdef MAC_SEQ_READBACK_EN
      vecs.push_back(mk(1'b0, 3'd7, 3'd7, 3'd7, 3'd5, 3'd0, 8'b0000_0001, 3'd6, 1'b0));
`endif
      vecs.push_back(mk(1'b0, 3'd7, 3'd7, 3'd7, 3'd6, 3'd0, 8'b0000_0001, 3'd0, 1'b1));
      vecs.push_back(mk(1'b0, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 8'b0000_0000, 3'd0, 1'b0));

      tick();
      do_reset();
      check("reset_dut1", 32'(obs1()), 32'd0);
      check("reset_dut2", 32'(obs2()), 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         start1 = vecs[i].start;
         a_base = vecs[i].a;
         b_base = vecs[i].b;
         ram_in = vecs[i].r;
         tick();
         check($sformatf("vec%0d", i + 1), 32'(obs1()),
               32'({vecs[i].st, vecs[i].rf, vecs[i].ctl, vecs[i].ram, vecs[i].done}));
      end

      // MUL_LAT=3 with A base wrapping 7 -> 0.
      do_reset();
      a_base = 3'd7; b_base = 3'd0; ram_in = 3'd1;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      cyc = 1; done_cyc = 0; mult_cnt = 0;
      while (cyc <= 40) begin
         if (w_rf2 && !da2) a_reads.push_back(rf2);
         if (en2) acc_cyc.push_back(cyc);
         if (st2 == 3'd3) mult_cnt++;
         if (done2) begin
            done_cyc = cyc;
            break;
         end
         tick();
         cyc++;
      end
      check("lat3_done_cycle", 32'(done_cyc), 32'(12 + c_RB));
      check("lat3_mult_cycles", 32'(mult_cnt), 32'd6);
      check("lat3_acc_en_count", 32'(acc_cyc.size()), 32'd2);
      check("lat3_acc_en_first", 32'(acc_cyc.size() > 0 ? acc_cyc[0] : -1), 32'd5);
      check("lat3_acc_en_second", 32'(acc_cyc.size() > 1 ? acc_cyc[1] : -1), 32'd10);
      check("wrap_a_count", 32'(a_reads.size()), 32'd2);
      check("wrap_a_first", 32'(a_reads.size() > 0 ? a_reads[0] : 3'bx), 32'd7);
      check("wrap_a_second", 32'(a_reads.size() > 1 ? a_reads[1] : 3'bx), 32'd0);

      // Start during LOAD_B is ignored; start held gives one IDLE gap.
      do_reset();
      a_base = 3'd2; b_base = 3'd4; ram_in = 3'd5;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      check("held_in_load_b", 32'(st1), 32'd2);
      start1 = 1'b1;
      tick();
      check("start_ignored_mult", 32'(st1), 32'd3);
      cyc = 3; done_cyc = 0;
      while (cyc <= 40) begin
         if (done1) begin
            done_cyc = cyc;
            break;
         end
         tick();
         cyc++;
      end
      check("held_done_cycle", 32'(done_cyc), 32'(exp_done));
      tick();
      check("held_idle_gap", 32'({st1, busy1}), 32'd0);
      tick();
      check("held_restart", 32'({st1, clr1, rf1}), 32'({3'd1, 1'b1, 3'd2}));
      start1 = 1'b0;

      // Reset during the second MULT; fresh start must begin at idx 0.
      do_reset();
      a_base = 3'd3; b_base = 3'd5; ram_in = 3'd6;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("second_mult_reached", 32'({st1, en1}), 32'({3'd3, 1'b1}));
      reset = 1'b1;
      tick();
      check("reset_mid_mult", 32'(obs1()), 32'd0);
      reset = 1'b0;
      a_base = 3'd2;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("restart_idx0", 32'({st1, clr1, rf1}), 32'({3'd1, 1'b1, 3'd2}));
      for (int i = 0; i < 12; i++) tick();

`ifndef MAC_SEQ_READBACK_EN
      check("no_state_5", 32'(n_five), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
